// File: rtl/and_gate_checker_pkg.sv
// and_gate_checker shared types.
// FSM encoding and test vector width.
package and_gate_checker_pkg;

  localparam int VEC_W = 2;

  typedef logic [VEC_W-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/and_gate_checker_if.sv
// and_gate_checker board-side bundle.
// master = checker, slave = gate under test / observer.
interface and_gate_checker_if #(
  parameter int ERR_W = 8
);

  logic             a;
  logic             b;
  logic             s;
  logic             sweep_done;
  logic [ERR_W-1:0] err_cnt;
  logic             led_fail;
  logic             led_pass;

  modport master (
    output a,
    output b,
    output sweep_done,
    output err_cnt,
    output led_fail,
    output led_pass,
    input  s
  );

  modport slave (
    input  a,
    input  b,
    input  sweep_done,
    input  err_cnt,
    input  led_fail,
    input  led_pass,
    output s
  );

endinterface

// File: rtl/and_gate_checker_sync_2ff.sv
// and_gate_checker 1-bit two-flop synchronizer.
// Async active-low reset to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/and_gate_checker.sv
// and_gate_checker top: sweeps a,b over 00..11,
// holds, samples s and scores against a&b.
module and_gate_checker
  import and_gate_checker_pkg::*;
#(
  parameter logic [24:0] HOLD_CNT = 25'd24_999_999,
  parameter int          ERR_W    = 8
) (
  input logic               sys_clk,
  input logic               sys_rst_n,
  and_gate_checker_if.master bus
);

  localparam int CW = $clog2(HOLD_CNT);
  localparam logic [CW-1:0] LAST =
    CW'(HOLD_CNT - 25'd1);

  state_t           r_state;
  vec_t             r_vec;
  logic [CW-1:0]    r_cnt;
  logic             r_a;
  logic             r_b;
  logic             r_sd;
  logic [ERR_W-1:0] r_err;
  logic             r_fail;
  logic             r_pass;

  logic w_s_sync;
  logic w_last_vec;
  logic w_miss;
  logic w_err_full;

  sync_2ff u_sync (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_d     (bus.s),
    .o_q     (w_s_sync)
  );

  // vector 11 is the only one whose AND is 1
  assign w_last_vec = &r_vec;
  assign w_miss     = w_s_sync ^ w_last_vec;
  assign w_err_full = &r_err;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_sd    <= 1'b0;
      r_err   <= '0;
      r_fail  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_sd <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_vec   <= '0;
          r_cnt   <= '0;
          r_state <= APPLY;
        end
        APPLY: begin
          r_a <= r_vec[1];
          r_b <= r_vec[0];
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= CHECK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (w_miss) begin
            r_fail <= 1'b1;
            r_pass <= 1'b0;
            if (!w_err_full)
              r_err <= r_err + 1'b1;
          end
          if (w_last_vec) begin
            r_sd <= 1'b1;
            if (!w_miss && !r_fail)
              r_pass <= 1'b1;
          end
          r_vec   <= r_vec + 1'b1;
          r_state <= APPLY;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.a          = r_a;
  assign bus.b          = r_b;
  assign bus.sweep_done = r_sd;
  assign bus.err_cnt    = r_err;
  assign bus.led_fail   = r_fail;
  assign bus.led_pass   = r_pass;

endmodule

// File: tb/tb_and_gate_checker.sv
// and_gate_checker bench: loopback gate with
// forcible s, cycle-indexed reference model.
module tb_and_gate_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic f_en = 1'b0;
  logic f_val = 1'b0;

  always #10 clk = ~clk;

  and_gate_checker_if #(.ERR_W(8)) bus ();

  assign bus.s = f_en ? f_val : (bus.a & bus.b);

  and_gate_checker #(
    .HOLD_CNT (25'd4),
    .ERR_W    (8)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  int errors = 0;
  int checks = 0;

  // model: n = edges since reset release (t0 = 0)
  int         n;
  logic       m_a, m_b, m_sd, m_fail, m_pass;
  logic [7:0] m_err;
  logic       s_hist[$];

  typedef struct {
    logic       fe;
    logic       fv;
    int         sweeps;
    logic [7:0] err;
    logic       fail;
    logic       pass;
  } rec_t;

  rec_t tbl[6];

  task automatic chk(string nm, logic [7:0] act,
                     logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h n=%0d",
               nm, act, exp, n);
    end
  endtask

  task automatic model_reset();
    n = -1;
    m_a = 0; m_b = 0; m_sd = 0;
    m_fail = 0; m_pass = 0; m_err = 0;
    s_hist.delete();
  endtask

  // vector j occupies edges 5j+1..5j+5; check at 5j+5
  task automatic model_edge();
    int j;
    logic [1:0] v;
    logic smp;
    logic want;
    m_sd = 0;
    if (n >= 1) begin
      v = 2'(((n - 1) / 5) % 4);
      m_a = v[1];
      m_b = v[0];
    end
    if (n >= 5 && n % 5 == 0) begin
      j = n / 5 - 1;
      v = 2'(j % 4);
      want = (v == 2'd3);
      smp = s_hist[n - 2];
      if (smp != want) begin
        m_fail = 1;
        m_pass = 0;
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
      end
      if (v == 2'd3) begin
        m_sd = 1;
        if (!m_fail) m_pass = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("a", 8'(bus.a), 8'(m_a));
    chk("b", 8'(bus.b), 8'(m_b));
    chk("sweep_done", 8'(bus.sweep_done), 8'(m_sd));
    chk("err_cnt", bus.err_cnt, m_err);
    chk("led_fail", 8'(bus.led_fail), 8'(m_fail));
    chk("led_pass", 8'(bus.led_pass), 8'(m_pass));
  endtask

  // s_hist[k] is the value of s at edge k
  task automatic tick();
    s_hist.push_back(f_en ? f_val : (m_a & m_b));
    @(posedge clk);
    n++;
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    f_en = 1'b0;
    f_val = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 3, 8'd0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 1, 8'd1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 3, 8'd3, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1, 8'd3, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 2, 8'd6, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 86, 8'hFF, 1'b1, 1'b0};

    for (int i = 0; i < 6; i++) begin
      do_reset();
      f_en = tbl[i].fe;
      f_val = tbl[i].fv;
      repeat (20 * tbl[i].sweeps + 1) tick();
      chk("tbl_err", bus.err_cnt, tbl[i].err);
      chk("tbl_fail", 8'(bus.led_fail), 8'(tbl[i].fail));
      chk("tbl_pass", 8'(bus.led_pass), 8'(tbl[i].pass));
    end

    // saturation holds for a further sweep
    f_en = 1'b1;
    f_val = 1'b1;
    repeat (20) tick();
    chk("sat_hold", bus.err_cnt, 8'hFF);

    // first sweep_done lands right after edge 20
    do_reset();
    while (n < 19) tick();
    chk("sd_pre", 8'(bus.sweep_done), 8'd0);
    tick();
    chk("sd_t20", 8'(bus.sweep_done), 8'd1);
    tick();
    chk("sd_post", 8'(bus.sweep_done), 8'd0);

    // async reset mid-APPLY of vector 10
    do_reset();
    f_en = 1'b1;
    f_val = 1'b1;
    while (n < 12) tick();
    chk("pre_rst_a", 8'(bus.a), 8'd1);
    chk("pre_rst_err", bus.err_cnt, 8'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a", 8'(bus.a), 8'd0);
    chk("rst_b", 8'(bus.b), 8'd0);
    chk("rst_err", bus.err_cnt, 8'd0);
    chk("rst_fail", 8'(bus.led_fail), 8'd0);
    chk("rst_pass", 8'(bus.led_pass), 8'd0);
    do_reset();
    repeat (21) tick();
    chk("restart_pass", 8'(bus.led_pass), 8'd1);

    // early-window glitch on vector 01 is ignored
    do_reset();
    while (n < 5) tick();
    f_en = 1'b1;
    f_val = 1'b1;
    tick();
    tick();
    f_en = 1'b0;
    while (n < 20) tick();
    chk("glitch_err", bus.err_cnt, 8'd0);
    chk("glitch_pass", 8'(bus.led_pass), 8'd1);

    // wrong only at sample of vector 10, sweep 2
    do_reset();
    while (n < 32) tick();
    chk("s6_pass_pre", 8'(bus.led_pass), 8'd1);
    f_en = 1'b1;
    f_val = 1'b1;
    tick();
    f_en = 1'b0;
    while (n < 34) tick();
    chk("s6_pass_34", 8'(bus.led_pass), 8'd1);
    tick();
    chk("s6_err", bus.err_cnt, 8'd1);
    chk("s6_fail", 8'(bus.led_fail), 8'd1);
    chk("s6_pass", 8'(bus.led_pass), 8'd0);
    repeat (10) tick();

    // random s corruption against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      f_en = ($urandom_range(0, 5) == 0);
      f_val = 1'($urandom_range(0, 1));
      tick();
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
